// File: rtl/spmv_pkg.sv
// Shared definitions for the spmv PE memory arbiter: bus widths, load-tag
// layout, store stride, requester indices and the output-queue entry format.
package spmv_pkg;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 64;

  // Load tag layout carried in req_mem_d_or_tag for loads
  localparam int TAG_X_BIT      = 0;
  localparam int TAG_STREAM_MSB = 2;
  localparam int TAG_STREAM_LSB = 1;

  // y-vector results are 64-bit doubles stored back to back
  localparam logic [ADDR_W-1:0] ST_STRIDE = 48'd8;

  // Bit positions of each requester inside valid/grant vectors
  typedef enum logic [1:0] {
    REQ_ST  = 2'd0,
    REQ_CX  = 2'd1,
    REQ_DEC = 2'd2
  } req_idx_e;

  typedef struct packed {
    logic              ld;
    logic              st;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
  } oq_entry_t;

  function automatic logic [DATA_W-1:0] load_tag(input logic is_x, input logic [1:0] stream);
    logic [DATA_W-1:0] t;
    t = '0;
    t[TAG_X_BIT] = is_x;
    t[TAG_STREAM_MSB:TAG_STREAM_LSB] = stream;
    return t;
  endfunction

endpackage

// File: rtl/spmv_mem_arbiter_if.sv
// PE memory request port. The arbiter is the master; the memory system
// drives the stall back.
interface spmv_mem_arbiter_if;
  import spmv_pkg::*;

  logic              req_mem_ld;
  logic              req_mem_st;
  logic [ADDR_W-1:0] req_mem_addr;
  logic [DATA_W-1:0] req_mem_d_or_tag;
  logic              req_mem_stall;

  modport master (
    output req_mem_ld,
    output req_mem_st,
    output req_mem_addr,
    output req_mem_d_or_tag,
    input  req_mem_stall
  );

  modport slave (
    input  req_mem_ld,
    input  req_mem_st,
    input  req_mem_addr,
    input  req_mem_d_or_tag,
    output req_mem_stall
  );
endinterface

// File: rtl/spmv_starve_prio.sv
// 3-way priority picker: fixed priority st > cx > dec, except that a
// requester which has lost STARVE_LIMIT arbitrations in a row is promoted
// (dec > cx > st among promoted requesters).
module spmv_starve_prio
  import spmv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       allow,
  input  logic [2:0] valid,
  output logic [2:0] grant
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt [3];
  logic [2:0]    starved;

  // promotion flags
  always_comb begin
    starved = '0;
    for (int i = 0; i < 3; i++) begin
      starved[i] = valid[i] && (cnt[i] == LIMIT);
    end
  end

  // one-hot grant, promoted requesters first
  always_comb begin
    grant = '0;
    if (allow) begin
      if      (starved[REQ_DEC]) grant[REQ_DEC] = 1'b1;
      else if (starved[REQ_CX])  grant[REQ_CX]  = 1'b1;
      else if (starved[REQ_ST])  grant[REQ_ST]  = 1'b1;
      else if (valid[REQ_ST])    grant[REQ_ST]  = 1'b1;
      else if (valid[REQ_CX])    grant[REQ_CX]  = 1'b1;
      else if (valid[REQ_DEC])   grant[REQ_DEC] = 1'b1;
    end
  end

  // saturating lost-arbitration counters; a cycle blocked by the queue
  // still counts as a loss for every waiting requester
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || !valid[i] || grant[i]) cnt[i] <= '0;
      else if (cnt[i] != LIMIT)         cnt[i] <= cnt[i] + 1'b1;
    end
  end

endmodule

// File: rtl/std_fifo.sv
// Generic synchronous FIFO. LATENCY 0 gives show-ahead read data; any other
// value registers the read word on rd_en. DEPTH must be a power of 2.
module std_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (count == '0);
  assign full  = count[AW];
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) store[wr_ptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  if (LATENCY == 0) begin : g_show_ahead
    assign rd_data = store[rd_ptr];
  end else begin : g_registered
    logic [WIDTH-1:0] rd_q;
    // registered read word
    always_ff @(posedge clk) begin
      if (rd_ok) rd_q <= store[rd_ptr];
    end
    assign rd_data = rd_q;
  end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// Merges y-stores, x-cache loads and decoder loads onto the PE memory port.
// Grants are issued only while the output queue has OQ_SLACK free entries,
// which absorbs the registered stall so the queue can never overflow.
module spmv_mem_arbiter
  import spmv_pkg::*;
#(
  parameter int unsigned OQ_DEPTH     = 32,
  parameter int unsigned OQ_SLACK     = 4,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [ADDR_W-1:0]    cfg_data,
  input  logic                 st_valid,
  input  logic [DATA_W-1:0]    st_data,
  output logic                 st_pop,
  input  logic                 cx_valid,
  input  logic [ADDR_W-1:0]    cx_addr,
  output logic                 cx_pop,
  input  logic                 dec_valid,
  input  logic [ADDR_W-1:0]    dec_addr,
  input  logic [1:0]           dec_tag,
  output logic                 dec_pop,
  spmv_mem_arbiter_if.master   mem,
  output logic [ADDR_W-1:0]    st_ptr,
  output logic                 range_done,
  output logic                 busy
);
  localparam int unsigned CNT_W = $clog2(OQ_DEPTH) + 1;

  logic [ADDR_W-1:0] end_ptr;
  logic [2:0]        grant;
  logic              allow;
  logic              enq;
  oq_entry_t         enq_entry;
  oq_entry_t         oq_head;
  logic              oq_empty;
  logic              oq_full;
  logic [CNT_W-1:0]  oq_count;
  logic [CNT_W-1:0]  oq_free;
  logic              stall_r;
  logic              deq;

  assign oq_free    = CNT_W'(OQ_DEPTH) - oq_count;
  assign allow      = !rst && !oq_full && (oq_free >= CNT_W'(OQ_SLACK));
  assign range_done = (st_ptr == end_ptr);

  spmv_starve_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .allow (allow),
    .valid ({dec_valid, cx_valid, st_valid}),
    .grant (grant)
  );

  assign st_pop  = grant[REQ_ST];
  assign cx_pop  = grant[REQ_CX];
  assign dec_pop = grant[REQ_DEC];

  // build the queue entry for whichever requester won; stores past the
  // end pointer are consumed but dropped
  always_comb begin
    enq       = 1'b0;
    enq_entry = '0;
    if (grant[REQ_ST]) begin
      enq            = !range_done;
      enq_entry.st   = 1'b1;
      enq_entry.addr = st_ptr;
      enq_entry.d    = st_data;
    end else if (grant[REQ_CX]) begin
      enq            = 1'b1;
      enq_entry.ld   = 1'b1;
      enq_entry.addr = cx_addr;
      enq_entry.d    = load_tag(1'b1, 2'b00);
    end else if (grant[REQ_DEC]) begin
      enq            = 1'b1;
      enq_entry.ld   = 1'b1;
      enq_entry.addr = dec_addr;
      enq_entry.d    = load_tag(1'b0, dec_tag);
    end
  end

  // store range registers; a start write wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      st_ptr  <= '0;
      end_ptr <= '0;
    end else begin
      if (grant[REQ_ST] && !range_done) st_ptr <= st_ptr + ST_STRIDE;
      if (cfg_we && !cfg_sel)           st_ptr <= cfg_data;
      if (cfg_we && cfg_sel)            end_ptr <= cfg_data;
    end
  end

  std_fifo #(
    .WIDTH   ($bits(oq_entry_t)),
    .DEPTH   (OQ_DEPTH),
    .LATENCY (0)
  ) u_oq (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enq),
    .wr_data (enq_entry),
    .rd_en   (deq),
    .rd_data (oq_head),
    .empty   (oq_empty),
    .full    (oq_full),
    .count   (oq_count)
  );

  assign deq = !oq_empty && !stall_r;

  // output register: one-cycle strobes, address/data hold between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r              <= 1'b0;
      mem.req_mem_ld       <= 1'b0;
      mem.req_mem_st       <= 1'b0;
      mem.req_mem_addr     <= '0;
      mem.req_mem_d_or_tag <= '0;
    end else begin
      stall_r        <= mem.req_mem_stall;
      mem.req_mem_ld <= deq && oq_head.ld;
      mem.req_mem_st <= deq && oq_head.st;
      if (deq) begin
        mem.req_mem_addr     <= oq_head.addr;
        mem.req_mem_d_or_tag <= oq_head.d;
      end
    end
  end

  // activity flag, registered
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= st_valid || cx_valid || dec_valid || !oq_empty ||
                     mem.req_mem_ld || mem.req_mem_st;
  end

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
module tb_spmv_mem_arbiter;
  import spmv_pkg::*;

  localparam int OQ_DEPTH = 16;
  localparam int OQ_SLACK = 4;
  localparam int STARVE_LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_sel;
  logic [47:0] cfg_data;
  logic        st_valid, cx_valid, dec_valid;
  logic [63:0] st_data;
  logic [47:0] cx_addr, dec_addr;
  logic [1:0]  dec_tag;
  logic        st_pop, cx_pop, dec_pop;
  logic [47:0] st_ptr;
  logic        range_done, busy;

  always #5 clk = ~clk;

  spmv_mem_arbiter_if mem_if ();

  spmv_mem_arbiter #(
    .OQ_DEPTH(OQ_DEPTH), .OQ_SLACK(OQ_SLACK), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .st_valid(st_valid), .st_data(st_data), .st_pop(st_pop),
    .cx_valid(cx_valid), .cx_addr(cx_addr), .cx_pop(cx_pop),
    .dec_valid(dec_valid), .dec_addr(dec_addr), .dec_tag(dec_tag), .dec_pop(dec_pop),
    .mem(mem_if), .st_ptr(st_ptr), .range_done(range_done), .busy(busy)
  );

  typedef struct { logic ld; logic st; logic [47:0] addr; logic [63:0] d; } req_t;
  typedef struct {
    int kind;  // 0 st, 1 cx, 2 dec
    logic [47:0] addr; logic [1:0] tag; logic [63:0] data;
    logic exp_ld; logic exp_st; logic [47:0] exp_addr; logic [63:0] exp_d;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] st_src[$];
  logic [47:0] cx_src[$];
  logic [49:0] dec_src[$];
  int          pop_seq[$];
  int          st_pops = 0, cx_pops = 0, dec_pops = 0;
  logic        st_took, cx_took, dec_took;

  req_t        sb[$];
  req_t        got[$];
  req_t        cur, e;
  int          strobe_cnt = 0;
  logic [47:0] m_ptr = '0, m_end = '0;

  vec_t        tbl[8];
  int          n0, d0, s0, k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // source models: show-ahead queues, head consumed after a sampled pop
  initial begin
    st_valid = 1'b0; st_data = '0; cx_valid = 1'b0; cx_addr = '0;
    dec_valid = 1'b0; dec_addr = '0; dec_tag = '0;
    forever begin
      @(negedge clk);
      st_took = st_pop; cx_took = cx_pop; dec_took = dec_pop;
      @(posedge clk);
      #1;
      if (st_took) begin
        st_pops++; pop_seq.push_back(0);
        check("st_pop_valid", st_src.size() != 0, 1);
        if (st_src.size() != 0) void'(st_src.pop_front());
      end
      if (cx_took) begin
        cx_pops++; pop_seq.push_back(1);
        check("cx_pop_valid", cx_src.size() != 0, 1);
        if (cx_src.size() != 0) void'(cx_src.pop_front());
      end
      if (dec_took) begin
        dec_pops++; pop_seq.push_back(2);
        check("dec_pop_valid", dec_src.size() != 0, 1);
        if (dec_src.size() != 0) void'(dec_src.pop_front());
      end
      st_valid  = st_src.size() != 0;
      st_data   = st_valid ? st_src[0] : '0;
      cx_valid  = cx_src.size() != 0;
      cx_addr   = cx_valid ? cx_src[0] : '0;
      dec_valid = dec_src.size() != 0;
      dec_addr  = dec_valid ? dec_src[0][47:0] : '0;
      dec_tag   = dec_valid ? dec_src[0][49:48] : '0;
    end
  end

  // monitor + reference model: strobes checked against scoreboard, expected
  // entries pushed when a requester is consumed
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("st_ptr_model", st_ptr, m_ptr);
        check("range_done_model", range_done, m_ptr == m_end);
        if (mem_if.req_mem_ld || mem_if.req_mem_st) begin
          cur.ld = mem_if.req_mem_ld; cur.st = mem_if.req_mem_st;
          cur.addr = mem_if.req_mem_addr; cur.d = mem_if.req_mem_d_or_tag;
          got.push_back(cur);
          strobe_cnt++;
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_strobe: addr %0h d %0h, none expected", cur.addr, cur.d);
          end else begin
            e = sb.pop_front();
            check("sb_kind", {cur.ld, cur.st}, {e.ld, e.st});
            check("sb_addr", cur.addr, e.addr);
            check("sb_data", cur.d, e.d);
          end
        end
        if (st_pop || cx_pop || dec_pop)
          check("pop_onehot", $countones({st_pop, cx_pop, dec_pop}), 1);
        if (st_pop && m_ptr != m_end) begin
          sb.push_back('{1'b0, 1'b1, m_ptr, st_data});
          m_ptr = m_ptr + 48'd8;
        end
        if (cx_pop)  sb.push_back('{1'b1, 1'b0, cx_addr, 64'h1});
        if (dec_pop) sb.push_back('{1'b1, 1'b0, dec_addr, {61'd0, dec_tag, 1'b0}});
        if (cfg_we) begin
          if (cfg_sel) m_end = cfg_data;
          else         m_ptr = cfg_data;
        end
      end else begin
        sb.delete();
        m_ptr = '0; m_end = '0;
      end
    end
  end

  task automatic cfg_write(input logic sel, input logic [47:0] data);
    @(posedge clk); #2;
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    @(posedge clk); #2;
    cfg_we = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int c = 0;
    while (strobe_cnt < target && c < budget) begin @(posedge clk); c++; end
    #2;
    if (strobe_cnt < target) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: %0d strobes seen, need %0d", name, strobe_cnt, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while ((sb.size() != 0 || st_src.size() != 0 || cx_src.size() != 0 ||
            dec_src.size() != 0) && c < budget) begin
      @(posedge clk); c++;
    end
    repeat (4) @(posedge clk);
    #2;
    check({name, "_drained"}, sb.size() + st_src.size() + cx_src.size() + dec_src.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
    mem_if.req_mem_stall = 1'b0;

    tbl[0] = '{1, 48'h2000,         2'd0, 64'd0, 1'b1, 1'b0, 48'h2000,         64'h1};
    tbl[1] = '{2, 48'h3000,         2'd2, 64'd0, 1'b1, 1'b0, 48'h3000,         64'h4};
    tbl[2] = '{2, 48'hFFFFFFFFFFF8, 2'd3, 64'd0, 1'b1, 1'b0, 48'hFFFFFFFFFFF8, 64'h6};
    tbl[3] = '{2, 48'h123456789ABC, 2'd1, 64'd0, 1'b1, 1'b0, 48'h123456789ABC, 64'h2};
    tbl[4] = '{2, 48'h10,           2'd0, 64'd0, 1'b1, 1'b0, 48'h10,           64'h0};
    tbl[5] = '{1, 48'hABCDEF012345, 2'd0, 64'd0, 1'b1, 1'b0, 48'hABCDEF012345, 64'h1};
    tbl[6] = '{0, 48'd0, 2'd0, 64'h3FF0000000000000, 1'b0, 1'b1, 48'h1000, 64'h3FF0000000000000};
    tbl[7] = '{0, 48'd0, 2'd0, 64'h4000000000000000, 1'b0, 1'b1, 48'h1008, 64'h4000000000000000};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ld", mem_if.req_mem_ld, 0);
    check("rst_st", mem_if.req_mem_st, 0);
    check("rst_addr", mem_if.req_mem_addr, 0);
    check("rst_data", mem_if.req_mem_d_or_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_st_ptr", st_ptr, 0);
    check("rst_range_done", range_done, 1);
    check("rst_pops", {st_pop, cx_pop, dec_pop}, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // table vectors: single requests, range 0x1000..0x1010 for stores
    cfg_write(1'b0, 48'h1000);
    cfg_write(1'b1, 48'h1010);
    for (int i = 0; i < 8; i++) begin
      n0 = strobe_cnt;
      case (tbl[i].kind)
        0:       st_src.push_back(tbl[i].data);
        1:       cx_src.push_back(tbl[i].addr);
        default: dec_src.push_back({tbl[i].tag, tbl[i].addr});
      endcase
      wait_strobes(n0 + 1, 20, "table");
      if (got.size() > n0) begin
        check("tbl_ld", got[n0].ld, tbl[i].exp_ld);
        check("tbl_st", got[n0].st, tbl[i].exp_st);
        check("tbl_addr", got[n0].addr, tbl[i].exp_addr);
        check("tbl_data", got[n0].d, tbl[i].exp_d);
      end
      repeat (2) @(posedge clk);
    end

    // third store past the end pointer: consumed, dropped, pointer holds
    n0 = strobe_cnt; s0 = st_pops;
    st_src.push_back(64'h4008000000000000);
    repeat (8) @(posedge clk);
    #2;
    check("drop_popped", st_pops, s0 + 1);
    check("drop_no_strobe", strobe_cnt, n0);
    check("drop_range_done", range_done, 1);
    check("drop_st_ptr", st_ptr, 48'h1010);

    // cx and dec one cycle apart
    n0 = strobe_cnt;
    cx_src.push_back(48'h2000);
    @(posedge clk); #2;
    dec_src.push_back({2'd2, 48'h3000});
    wait_strobes(n0 + 2, 20, "tag_pair");
    if (got.size() >= n0 + 2) begin
      check("pair0_addr", got[n0].addr, 48'h2000);
      check("pair0_data", got[n0].d, 64'h1);
      check("pair1_addr", got[n0+1].addr, 48'h3000);
      check("pair1_data", got[n0+1].d, 64'h4);
    end
    wait_idle(50, "tag_pair");

    // starvation: st and dec both held valid
    cfg_write(1'b0, 48'h40000);
    cfg_write(1'b1, 48'h80000);
    pop_seq.delete();
    for (int i = 0; i < 40; i++) begin
      st_src.push_back(64'(i) + 64'h100);
      dec_src.push_back({2'(i), 48'h9000 + 48'(i * 8)});
    end
    k = 0;
    while (pop_seq.size() < 32 && k < 200) begin @(posedge clk); k++; end
    #2;
    check("starve_grants", pop_seq.size() >= 32, 1);
    for (int g = 0; g < 32 && g < pop_seq.size(); g++)
      check("starve_order", pop_seq[g], (g % 16 == 15) ? 2 : 0);
    wait_idle(400, "starve");

    // start-pointer write in the same cycle as a store grant
    cfg_write(1'b0, 48'h5000);
    cfg_write(1'b1, 48'h6000);
    n0 = strobe_cnt;
    st_src.push_back(64'hAAAA5555AAAA5555);
    @(posedge clk); #2;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 48'h7000;
    @(negedge clk);
    check("cfg_race_pop", st_pop, 1);
    @(posedge clk); #2;
    cfg_we = 1'b0;
    check("cfg_race_ptr", st_ptr, 48'h7000);
    wait_strobes(n0 + 1, 20, "cfg_race");
    if (got.size() > n0) check("cfg_race_addr", got[n0].addr, 48'h5000);

    // backpressure: 20 decoder loads against a 30-cycle stall
    mem_if.req_mem_stall = 1'b1;
    n0 = strobe_cnt; d0 = dec_pops;
    for (int i = 0; i < 20; i++) dec_src.push_back({2'(i), 48'hA000 + 48'(i * 8)});
    repeat (30) @(posedge clk);
    #2;
    check("bp_pops_capped", dec_pops - d0, OQ_DEPTH - OQ_SLACK + 1);
    check("bp_no_strobe", strobe_cnt, n0);
    check("bp_busy", busy, 1);
    mem_if.req_mem_stall = 1'b0;
    @(posedge clk); #2;
    check("bp_no_strobe_plus1", strobe_cnt, n0);
    wait_strobes(n0 + 20, 80, "bp");
    check("bp_all_popped", dec_pops - d0, 20);
    if (got.size() >= n0 + 20)
      for (int i = 0; i < 20; i++) begin
        check("bp_order_addr", got[n0+i].addr, 48'hA000 + 48'(i * 8));
        check("bp_order_tag", got[n0+i].d, {61'd0, 2'(i), 1'b0});
      end
    wait_idle(50, "bp");

    // reset with five entries queued behind a stall
    mem_if.req_mem_stall = 1'b1;
    d0 = dec_pops;
    for (int i = 0; i < 5; i++) dec_src.push_back({2'd1, 48'hB000 + 48'(i * 8)});
    repeat (12) @(posedge clk);
    #2;
    check("rstq_popped", dec_pops - d0, 5);
    rst = 1'b1; mem_if.req_mem_stall = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("rstq_ld", mem_if.req_mem_ld, 0);
    check("rstq_st", mem_if.req_mem_st, 0);
    check("rstq_busy", busy, 0);
    check("rstq_st_ptr", st_ptr, 0);
    n0 = strobe_cnt;
    repeat (6) @(posedge clk);
    #2;
    check("rstq_discarded", strobe_cnt, n0);
    check("rstq_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spmv_mem_arbiter.md
Name: spmv_mem_arbiter

Overview:
- Merges the three memory requesters inside an spmv PE into the single PE memory port: y-vector stores from the MAC result queue, x-vector loads from the x cache, and matrix-stream loads from the sparse decoder.
- Owns the store address counter, response-tag encoding, starvation-bounded priority arbitration and a stall-tolerant output queue.
- Replaces the ad-hoc pop/priority logic and the request FIFO in the PE top level.

Parameters:
- OQ_DEPTH, 32, output request queue depth (power of 2, >=8).
- OQ_SLACK, 4, free queue entries required before a grant is issued.
- STARVE_LIMIT, 15, consecutive lost arbitrations after which a waiting requester is promoted to top priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  write store-range register
- cfg_sel  in  1  0 = store start pointer, 1 = store end pointer
- cfg_data  in  48  byte address written by cfg_we
- st_valid  in  1  MAC result available (show-ahead source)
- st_data  in  64  MAC result value
- st_pop  out  1  consume MAC result
- cx_valid  in  1  x-cache load pending
- cx_addr  in  48  x-cache load address
- cx_pop  out  1  consume x-cache request
- dec_valid  in  1  decoder load pending
- dec_addr  in  48  decoder load address
- dec_tag  in  2  decoder stream id
- dec_pop  out  1  consume decoder request
- req_mem_ld  out  1  load request strobe
- req_mem_st  out  1  store request strobe
- req_mem_addr  out  48  request address
- req_mem_d_or_tag  out  64  store data, or load tag
- req_mem_stall  in  1  memory port backpressure
- st_ptr  out  48  current store pointer
- range_done  out  1  st_ptr == end pointer
- busy  out  1  any valid input, queue entry or registered request outstanding

Behaviour:
- Reset: all pops, req_mem_ld/st, busy, starvation counters and queue count = 0; st_ptr = 0; end pointer = 0; req_mem_addr and req_mem_d_or_tag = 0.
- Config: cfg_we writes the selected register at the clock edge. A start-pointer write overrides any same-cycle increment.
- Grant (combinational, cycle N):
  - No grant when queue free entries < OQ_SLACK.
  - Otherwise a requester whose starvation counter == STARVE_LIMIT wins; if several qualify, order is dec > cx > st.
  - Otherwise fixed priority st > cx > dec.
  - At most one pop per cycle.
- Starvation counters: a valid, non-granted requester's counter increments, saturating at STARVE_LIMIT. The counter clears when that requester is granted or its valid is low.
- Enqueue (edge ending cycle N) for the granted requester:
  - st: entry {st=1, addr=st_ptr, d=st_data}; st_ptr += 8. If range_done, the pop still occurs but nothing is enqueued and st_ptr holds (the result is discarded).
  - cx: entry {ld=1, addr=cx_addr, d=64'h1}.
  - dec: entry {ld=1, addr=dec_addr, d bit0=0, bits2:1=dec_tag, others 0}.
- Output stage:
  - stall_r = req_mem_stall registered.
  - Dequeue when the queue is non-empty and !stall_r. The entry is registered onto req_mem_*, with the ld/st strobe high for exactly that cycle.
  - Otherwise the strobes are 0 and addr/data hold.
  - Minimum latency from pop to strobe: 2 cycles.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - The queue never overflows; OQ_SLACK covers the stall_r latency.
- Address arithmetic: st_ptr wraps modulo 2^48, no flag.
- busy is registered, asserted one cycle after any source of activity, and deasserts one cycle after the last strobe with all valids low.
- Reset mid-operation: queue contents are discarded, no strobe the following cycle, pointers return to 0.

Decomposition:
- Shared package spmv_pkg: tag bit positions (TAG_X_BIT=0, TAG_STREAM msb/lsb = 2:1), store stride constant 8, requester index encodings.
- The output queue reuses the existing std_fifo (LATENCY 0) instance.
- One natural sub-module: spmv_starve_prio, the 3-way priority picker with saturating starvation counters.

Test Plan:
- Range and drop: cfg start=0x1000, end=0x1010; three st_valid results 1.0, 2.0, 3.0 with no other traffic -> stores at 0x1000 and 0x1008 carrying 1.0 and 2.0, third popped and dropped, range_done=1, st_ptr=0x1010.
- Tag encoding: cx_addr=0x2000, and dec_addr=0x3000 with dec_tag=2 one cycle apart -> ld 0x2000 with d=0x1, then ld 0x3000 with d=0x4.
- Starvation: st_valid and dec_valid held high continuously with STARVE_LIMIT=15 -> dec granted on every 16th grant cycle, st on the others.
- Backpressure: 20 dec requests with req_mem_stall high for 30 cycles -> no strobes during the stall window plus 1 cycle, no pops once free entries < 4, all 20 issued in order after release, none lost or duplicated.
- Simultaneous config and increment: cfg start write in the same cycle as a store grant -> st_ptr takes the new start value.
- Reset mid-stream: rst pulsed with 5 entries queued -> strobes 0 the next cycle, busy=0 after 1 cycle, st_ptr=0.
